complex_result_serializer: RTL and testbench

- Sink for the wide result bundle of complex_matrix_mul: accepts all 2*SIZE result words in one valid/ready handshake, then streams them out one complex element per cycle.
- Each output beat is a (real, imag) pair, element index and last flag, with its own valid/ready handshake.
- Sits between the multiplier's result port and narrow downstream consumers: writeback, scoreboard, memory.

---
 rtl/complex_pkg.sv | 18 +
 rtl/complex_result_serializer.sv | 90 +++++++++
 tb/tb_complex_result_serializer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/complex_pkg.sv
// Shared types for the complex matrix datapath: element struct, serializer
// FSM states and word-per-element count.
package complex_pkg;

    localparam int CPLX_W     = 64;
    localparam int CPLX_WORDS = 2;

    typedef struct packed {
        logic [CPLX_W-1:0] re;
        logic [CPLX_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } serializer_state_e;

endpackage

// File: rtl/complex_result_serializer.sv
// Captures a full 2*SIZE-word complex result bundle in one handshake and
// streams it out one (real, imag) element per accepted beat.
module complex_result_serializer
    import complex_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int WIDTH = 64,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [CPLX_WORDS*SIZE-1:0][WIDTH-1:0] result_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [WIDTH-1:0]                    out_real_o,
    output logic [WIDTH-1:0]                    out_imag_o,
    output logic [IDX_W-1:0]                    out_idx_o,
    output logic                                out_last_o,
    output logic                                busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    serializer_state_e state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CPLX_WORDS*SIZE-1:0][WIDTH-1:0] buf_q;

    logic              capture;
    logic              beat_hs;
    logic [IDX_W:0]    re_sel;
    logic [IDX_W:0]    im_sel;

    assign re_sel = {idx_q, 1'b0};
    assign im_sel = {idx_q, 1'b1};

    always_comb begin
        out_valid_o = (state_q == DRAIN);
        busy_o      = (state_q == DRAIN);
        out_last_o  = (state_q == DRAIN) && (idx_q == LAST_IDX);
        out_idx_o   = idx_q;
        out_real_o  = buf_q[re_sel];
        out_imag_o  = buf_q[im_sel];
        // In DRAIN a new bundle is only taken on the final beat's handshake,
        // which is what lets consecutive bundles stream without a bubble.
        in_ready_o  = (state_q == IDLE) ? 1'b1 : (out_ready_i & out_last_o);
    end

    assign capture = in_valid_i & in_ready_o & ~flush_i;
    assign beat_hs = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (capture) begin
            state_d = DRAIN;
            idx_d   = '0;
        end else if (beat_hs) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Data buffer carries no reset; its contents only matter once captured.
    always_ff @(posedge clk_i) begin
        if (capture && !rst_i) begin
            buf_q <= result_i;
        end
    end

endmodule

// File: tb/tb_complex_result_serializer.sv
// Directed, self-checking bench for complex_result_serializer (SIZE=16).
module tb_complex_result_serializer;
    import complex_pkg::*;

    localparam int SIZE  = 16;
    localparam int WIDTH = 64;
    localparam int IDX_W = 4;

    typedef logic [2*SIZE-1:0][WIDTH-1:0] bundle_t;

    typedef struct {
        bit rdy;
        int exp_idx;
    } bp_vec_t;

    logic             clk = 1'b0;
    logic             rst_i, flush_i, in_valid_i, out_ready_i;
    logic             in_ready_o, out_valid_o, out_last_o, busy_o;
    bundle_t          result_i;
    logic [WIDTH-1:0] out_real_o, out_imag_o;
    logic [IDX_W-1:0] out_idx_o;

    int n_chk  = 0;
    int n_fail = 0;

    complex_result_serializer #(.SIZE(SIZE), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .result_i   (result_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_real_o (out_real_o),
        .out_imag_o (out_imag_o),
        .out_idx_o  (out_idx_o),
        .out_last_o (out_last_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // element i = (i+1.0, -(i+1.0))
    function automatic bundle_t ramp_bundle();
        bundle_t b;
        for (int i = 0; i < SIZE; i++) begin
            b[2*i]   = $realtobits(real'(i + 1));
            b[2*i+1] = $realtobits(-real'(i + 1));
        end
        return b;
    endfunction

    // all reals = re, imag = element index
    function automatic bundle_t const_bundle(input logic [63:0] re);
        bundle_t b;
        for (int i = 0; i < SIZE; i++) begin
            b[2*i]   = re;
            b[2*i+1] = 64'(i);
        end
        return b;
    endfunction

    function automatic bundle_t fill_bundle(input logic [63:0] w);
        bundle_t b;
        for (int i = 0; i < 2*SIZE; i++) b[i] = w;
        return b;
    endfunction

    // Compares the current beat against element idx of bundle b; call after negedge.
    task automatic check_beat(input string tag, input bundle_t b, input int idx);
        cplx_t e;
        e.re = b[2*idx];
        e.im = b[2*idx+1];
        chk({tag, ".valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, ".idx"},   64'(out_idx_o),   64'(idx));
        chk({tag, ".real"},  out_real_o,       e.re);
        chk({tag, ".imag"},  out_imag_o,       e.im);
        chk({tag, ".last"},  64'(out_last_o),  64'(idx == SIZE-1));
        chk({tag, ".busy"},  64'(busy_o),      64'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, ".busy"},  64'(busy_o),      64'd0);
        chk({tag, ".inrdy"}, 64'(in_ready_o),  64'd1);
        chk({tag, ".last"},  64'(out_last_o),  64'd0);
    endtask

    // Presents bundle b for one cycle in IDLE and lets it be captured.
    task automatic load(input bundle_t b);
        result_i   = b;
        in_valid_i = 1'b1;
        @(negedge clk);
        chk("load.inrdy", 64'(in_ready_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
    endtask

    bp_vec_t bp_tab[32];
    bundle_t ba, bb, bnan;
    logic [63:0] prev_re, prev_im;
    logic [IDX_W-1:0] prev_idx;

    initial begin
        // Pattern 1,0,0,1 per 4 cycles: idx within a block is 0,1,1,1 (+2 per block).
        for (int c = 0; c < 32; c++) begin
            bp_tab[c].rdy     = (c % 4 == 0) || (c % 4 == 3);
            bp_tab[c].exp_idx = (c / 4) * 2 + ((c % 4 == 0) ? 0 : 1);
        end

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        result_i = '0;
        tick(); tick();
        @(negedge clk);
        check_idle("reset");
        chk("reset.idx", 64'(out_idx_o), 64'd0);
        tick();
        rst_i = 1'b0;

        // Single bundle, full throughput
        ba = ramp_bundle();
        load(ba);
        for (int b = 0; b < SIZE; b++) begin
            @(negedge clk);
            check_beat("single", ba, b);
            chk("single.inrdy", 64'(in_ready_o), 64'(b == SIZE-1));
            tick();
        end
        @(negedge clk);
        check_idle("single.after");
        tick();

        // Backpressure with isolation: result_i is trashed during DRAIN
        load(ba);
        result_i = fill_bundle(64'hFFF8000000000001);
        for (int c = 0; c < 32; c++) begin
            out_ready_i = bp_tab[c].rdy;
            @(negedge clk);
            check_beat("bp", ba, bp_tab[c].exp_idx);
            if (c > 0 && !bp_tab[c-1].rdy) begin
                chk("bp.stall_re",  out_real_o,      prev_re);
                chk("bp.stall_im",  out_imag_o,      prev_im);
                chk("bp.stall_idx", 64'(out_idx_o),  64'(prev_idx));
            end
            prev_re = out_real_o; prev_im = out_imag_o; prev_idx = out_idx_o;
            tick();
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        check_idle("bp.after");
        tick();

        // Back-to-back bundles, no bubble
        ba = const_bundle(64'h3ff0000000000000);
        bb = const_bundle(64'h4000000000000000);
        result_i   = ba;
        in_valid_i = 1'b1;
        tick();
        result_i = bb;
        for (int c = 0; c < 2*SIZE; c++) begin
            @(negedge clk);
            check_beat(c < SIZE ? "b2b.A" : "b2b.B", c < SIZE ? ba : bb, c % SIZE);
            if (c == SIZE-1) chk("b2b.inrdy_last", 64'(in_ready_o), 64'd1);
            tick();
            if (c == SIZE-1) in_valid_i = 1'b0;
        end
        @(negedge clk);
        check_idle("b2b.after");
        tick();

        // Flush at idx 5 together with a new bundle: flush wins
        ba = ramp_bundle();
        load(ba);
        for (int b = 0; b < 5; b++) tick();
        @(negedge clk);
        check_beat("flush.pre", ba, 5);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        result_i   = const_bundle(64'h4000000000000000);
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        check_idle("flush.post");
        chk("flush.idx", 64'(out_idx_o), 64'd0);
        tick();
        @(negedge clk);
        check_idle("flush.nocap");
        tick();

        // NaN payload passes bit-exact; new bundle restarts at idx 0
        bnan = fill_bundle(64'hFFF8000000000001);
        load(bnan);
        @(negedge clk);
        check_beat("nan", bnan, 0);
        tick();
        @(negedge clk);
        check_beat("nan", bnan, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check_idle("nan.rst");
        tick();

        // Reset mid-drain at idx 9
        load(ba);
        for (int b = 0; b < 9; b++) tick();
        @(negedge clk);
        check_beat("rst.pre", ba, 9);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check_idle("rst.post");
        chk("rst.idx", 64'(out_idx_o), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
